// File: rtl/multi_mode_timer_pkg.sv
// Shared types for the multi-mode timer: FSM state encoding and mode constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/multi_mode_timer_if.sv
// Control/status bundle of the multi-mode timer; master drives control, slave is the timer.
interface multi_mode_timer_if #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
);
    logic [WIDTH-1:0]      load_value;
    logic [PRESCALE_W-1:0] prescale;
    logic                  mode;
    logic                  start;
    logic                  stop;
    logic                  pause;
    logic [WIDTH-1:0]      o_count;
    logic                  o_busy;
    logic                  o_time_over;

    modport master (
        output load_value, prescale, mode, start, stop, pause,
        input  o_count, o_busy, o_time_over
    );

    modport slave (
        input  load_value, prescale, mode, start, stop, pause,
        output o_count, o_busy, o_time_over
    );
endinterface

// File: rtl/multi_mode_timer_prescaler.sv
// Clock divider: one tick every prescale+1 enabled clocks, restartable via clear.
module timer_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt;

    // >= so a prescale lowered below the running count wraps at once instead of
    // running the full counter range before the next tick.
    assign tick = enable && !clear && (cnt >= prescale);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)      cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (tick)   cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/multi_mode_timer.sv
// Multi-mode down-counting timer: one-shot or periodic, prescaled ticks, pause and abort.
module multi_mode_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    multi_mode_timer_if.slave    bus
);
    state_t           state;
    logic [WIDTH-1:0] count;
    logic             mode_q;
    logic             busy;
    logic             time_over;
    logic             start_ok;
    logic             active;
    logic             tick;

    assign start_ok = bus.start && (bus.load_value != '0);
    // PAUSED with pause low also counts, so a pause costs exactly its high cycles.
    assign active   = (state != IDLE) && !bus.pause;

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .enable   (active),
        .clear    (bus.stop || start_ok),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            count     <= '0;
            mode_q    <= ONE_SHOT;
            busy      <= 1'b0;
            time_over <= 1'b0;
        end else begin
            time_over <= 1'b0;
            if (bus.stop) begin
                state <= IDLE;
                count <= '0;
                busy  <= 1'b0;
            end else if (start_ok) begin
                count  <= bus.load_value;
                mode_q <= bus.mode;
                busy   <= 1'b1;
                state  <= (state == PAUSED && bus.pause) ? PAUSED : RUN;
            end else if (state != IDLE) begin
                if (bus.pause) begin
                    state <= PAUSED;
                end else begin
                    state <= RUN;
                    if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - 1'b1;
                        end else begin
                            time_over <= 1'b1;
                            if (mode_q == PERIODIC && bus.load_value != '0) begin
                                count <= bus.load_value;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign bus.o_count     = count;
    assign bus.o_busy      = busy;
    assign bus.o_time_over = time_over;
endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed bench for multi_mode_timer; expiry pulses are scored against a queue of expected cycles.
module tb_multi_mode_timer;
    logic CLK = 1'b0;
    logic RST_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   s;

    multi_mode_timer_if #(.WIDTH(16), .PRESCALE_W(8)) bus ();

    multi_mode_timer #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive a one-clock start; sn is the edge number at which it is sampled.
    task automatic do_start(input int ld, input int p, input logic m, output int sn);
        bus.load_value = 16'(ld);
        bus.prescale   = 8'(p);
        bus.mode       = m;
        bus.start      = 1'b1;
        sn = cyc + 1;
        @(posedge CLK);
        #1 bus.start = 1'b0;
    endtask

    // Expiry pulse scoreboard: each pulse must match the oldest expected cycle.
    always @(negedge CLK) begin
        if (RST_n === 1'b1 && bus.o_time_over === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", 32'(bus.o_time_over), 0);
            else chk("pulse_cycle", cyc, exp_q.pop_front());
        end else if (exp_q.size() > 0 && cyc >= exp_q[0]) begin
            chk("missed_pulse", cyc, exp_q.pop_front() - 1);
        end
    end

    initial begin
        RST_n = 1'b0;
        bus.load_value = '0; bus.prescale = '0; bus.mode = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        step(3);
        chk("rst_count", 32'(bus.o_count), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_time_over", 32'(bus.o_time_over), 0);
        RST_n = 1'b1;

        // one-shot, load 3, prescale 0
        do_start(3, 0, 1'b0, s);
        exp_q.push_back(s + 3);
        chk("s1_count3", 32'(bus.o_count), 3);
        chk("s1_busy", 32'(bus.o_busy), 1);
        step(1); chk("s1_count2", 32'(bus.o_count), 2);
        step(1); chk("s1_count1", 32'(bus.o_count), 1);
        step(1); chk("s1_count0", 32'(bus.o_count), 0);
        chk("s1_idle", 32'(bus.o_busy), 0);
        step(2); chk("s1_queue", exp_q.size(), 0);

        // periodic, load 2, prescale 3: pulse every 8 clocks
        do_start(2, 3, 1'b1, s);
        exp_q.push_back(s + 8);
        exp_q.push_back(s + 16);
        step(4);  chk("s2_count1", 32'(bus.o_count), 1);
        step(15); chk("s2_busy", 32'(bus.o_busy), 1);
        chk("s2_reload", 32'(bus.o_count), 2);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        chk("s2_stop_count", 32'(bus.o_count), 0);
        chk("s2_stop_busy", 32'(bus.o_busy), 0);
        step(10); chk("s2_queue", exp_q.size(), 0);

        // load 5, pause for 4 clocks at count 3: expiry slips by 4
        do_start(5, 0, 1'b0, s);
        exp_q.push_back(s + 9);
        step(2); chk("s3_count3", 32'(bus.o_count), 3);
        bus.pause = 1'b1;
        step(4);
        chk("s3_frozen", 32'(bus.o_count), 3);
        chk("s3_busy", 32'(bus.o_busy), 1);
        bus.pause = 1'b0;
        step(3); chk("s3_count0", 32'(bus.o_count), 0);
        step(2); chk("s3_queue", exp_q.size(), 0);

        // start and stop together while running: stop wins, no pulse
        do_start(4, 1, 1'b0, s);
        step(3); chk("s4_count3", 32'(bus.o_count), 3);
        bus.start = 1'b1; bus.stop = 1'b1;
        step(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("s4_count", 32'(bus.o_count), 0);
        chk("s4_busy", 32'(bus.o_busy), 0);
        step(12); chk("s4_queue", exp_q.size(), 0);

        // zero load ignored, then load 1 expires one clock later
        do_start(0, 0, 1'b0, s);
        chk("s5_zero_busy", 32'(bus.o_busy), 0);
        chk("s5_zero_count", 32'(bus.o_count), 0);
        step(2); chk("s5_still_idle", 32'(bus.o_busy), 0);
        do_start(1, 0, 1'b0, s);
        exp_q.push_back(s + 1);
        chk("s5_count1", 32'(bus.o_count), 1);
        chk("s5_busy", 32'(bus.o_busy), 1);
        step(1);
        chk("s5_count0", 32'(bus.o_count), 0);
        chk("s5_idle", 32'(bus.o_busy), 0);
        step(2); chk("s5_queue", exp_q.size(), 0);

        // reset mid-run at count 2: immediate clear, no pulse afterwards
        do_start(4, 0, 1'b0, s);
        step(2); chk("s6_count2", 32'(bus.o_count), 2);
        RST_n = 1'b0;
        #1;
        chk("s6_rst_count", 32'(bus.o_count), 0);
        chk("s6_rst_busy", 32'(bus.o_busy), 0);
        chk("s6_rst_time_over", 32'(bus.o_time_over), 0);
        step(2);
        RST_n = 1'b1;
        step(10);
        chk("s6_busy_after", 32'(bus.o_busy), 0);
        chk("s6_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
